booth_mul_seq: RTL and testbench

Sequencer for the shared iterative radix-2 Booth multiplier in the EX stage of the 32-bit pipelined MIPS core. It accepts one signed multiply per request and runs one Booth iteration per clock. While a multiply is in flight it holds a stall to the pipeline, then returns the 2*WIDTH-bit product with a one-cycle done pulse. The block contains the A/Q/q_1 working registers, the iteration counter and the control FSM.

---
 rtl/mul_pkg.sv | 17 +
 rtl/booth_step.sv | 32 +++
 rtl/booth_mul_seq.sv | 127 ++++++++++++
 tb/tb_booth_mul_seq.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mul_pkg.sv
// Shared types and constants for the iterative Booth multiplier.
// Holds the sequencer state enum, default width and Booth pair codes.
package mul_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam int DEFAULT_WIDTH = 32;

   // {Q[0], q_1} pairs that require an add or subtract of M
   localparam logic [1:0] BOOTH_ADD = 2'b01;
   localparam logic [1:0] BOOTH_SUB = 2'b10;

endpackage

// File: rtl/booth_step.sv
// One radix-2 Booth iteration: conditional add/sub of M into A, then an
// arithmetic shift right of {A,Q,q_1}.
// Ports: a_i/q_i/q1_i/m_i current working regs; a_o/q_o/q1_o next values.
module booth_step
   import mul_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic [WIDTH:0]   a_i,
   input  logic [WIDTH-1:0] q_i,
   input  logic             q1_i,
   input  logic [WIDTH:0]   m_i,
   output logic [WIDTH:0]   a_o,
   output logic [WIDTH-1:0] q_o,
   output logic             q1_o
);

   logic [WIDTH:0] sum;

   always_comb begin
      sum = a_i;
      case ({q_i[0], q1_i})
         BOOTH_ADD: sum = a_i + m_i;
         BOOTH_SUB: sum = a_i - m_i;
         default:   sum = a_i;
      endcase
      a_o  = {sum[WIDTH], sum[WIDTH:1]};
      q_o  = {sum[0], q_i[WIDTH-1:1]};
      q1_o = q_i[0];
   end

endmodule

// File: rtl/booth_mul_seq.sv
// Sequencer for the shared iterative Booth multiplier in EX: one iteration
// per clock, stalls the pipe while busy, pulses done with the product.
// Ports: clk, rst_n (sync, active-low), start, flush, multiplicand,
// multiplier in; busy, stall, done, product out.
// Optional macro MUL_ZERO_BYPASS_EN: a zero operand finishes in one cycle.
module booth_mul_seq
   import mul_pkg::*;
#(
   parameter  int WIDTH = DEFAULT_WIDTH,
   localparam int CNT_W = $clog2(WIDTH)
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic               flush,
   input  logic [WIDTH-1:0]   multiplicand,
   input  logic [WIDTH-1:0]   multiplier,
   output logic               busy,
   output logic               stall,
   output logic               done,
   output logic [2*WIDTH-1:0] product
);

   state_t               state_q, state_d;
   logic [WIDTH:0]       a_q, a_d;
   logic [WIDTH:0]       m_q, m_d;
   logic [WIDTH-1:0]     q_q, q_d;
   logic                 q1_q, q1_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [2*WIDTH-1:0]   product_q, product_d;

   logic [WIDTH:0]       a_n;
   logic [WIDTH-1:0]     q_n;
   logic                 q1_n;
   logic                 accept;
   logic                 load;

   booth_step #(.WIDTH(WIDTH)) u_step (
      .a_i  (a_q),
      .q_i  (q_q),
      .q1_i (q1_q),
      .m_i  (m_q),
      .a_o  (a_n),
      .q_o  (q_n),
      .q1_o (q1_n)
   );

   assign accept = start & ~flush;

   always_comb begin
      state_d   = state_q;
      a_d       = a_q;
      m_d       = m_q;
      q_d       = q_q;
      q1_d      = q1_q;
      cnt_d     = cnt_q;
      product_d = product_q;
      load      = 1'b0;
      unique case (state_q)
         IDLE, DONE: begin
            // DONE falls back to IDLE unless a back-to-back start lands
            state_d = IDLE;
            if (accept) begin
               load    = 1'b1;
               state_d = RUN;
`ifdef MUL_ZERO_BYPASS_EN
               if (multiplicand == '0 || multiplier == '0) begin
                  state_d   = DONE;
                  product_d = '0;
               end
`endif
            end
         end
         RUN: begin
            if (flush) begin
               state_d = IDLE;
               a_d     = '0;
               cnt_d   = '0;
            end else begin
               a_d  = a_n;
               q_d  = q_n;
               q1_d = q1_n;
               if (cnt_q == '0) begin
                  state_d   = DONE;
                  product_d = {a_n[WIDTH-1:0], q_n};
               end else begin
                  cnt_d = cnt_q - 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
      if (load) begin
         a_d   = '0;
         m_d   = {multiplicand[WIDTH-1], multiplicand};
         q_d   = multiplier;
         q1_d  = 1'b0;
         cnt_d = CNT_W'(WIDTH - 1);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         a_q       <= '0;
         m_q       <= '0;
         q_q       <= '0;
         q1_q      <= 1'b0;
         cnt_q     <= '0;
         product_q <= '0;
      end else begin
         state_q   <= state_d;
         a_q       <= a_d;
         m_q       <= m_d;
         q_q       <= q_d;
         q1_q      <= q1_d;
         cnt_q     <= cnt_d;
         product_q <= product_d;
      end
   end

   assign busy    = (state_q == RUN);
   assign stall   = busy | accept;
   assign done    = (state_q == DONE);
   assign product = product_q;

endmodule

// File: tb/tb_booth_mul_seq.sv
// Scoreboard bench for booth_mul_seq: directed multiplies push expected
// product and done cycle; a negedge monitor pops and compares on done.
module tb_booth_mul_seq;

   localparam int W = 32;

`ifdef MUL_ZERO_BYPASS_EN
   localparam int LAT_ZERO = 1;
`else
   localparam int LAT_ZERO = 33;
`endif

   typedef struct {
      logic [2*W-1:0] prod;
      int             cyc;
   } exp_t;

   logic           clk = 1'b0;
   logic           rst_n;
   logic           start;
   logic           flush;
   logic [W-1:0]   mcand;
   logic [W-1:0]   mplier;
   logic           busy;
   logic           stall;
   logic           done;
   logic [2*W-1:0] product;

   exp_t sb[$];
   int   cyc = 0;
   int   n_chk = 0;
   int   n_fail = 0;

   booth_mul_seq #(.WIDTH(W)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .start        (start),
      .flush        (flush),
      .multiplicand (mcand),
      .multiplier   (mplier),
      .busy         (busy),
      .stall        (stall),
      .done         (done),
      .product      (product)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act,
                      input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (cycle %0d)",
                  name, act, exp, cyc);
      end
   endtask

   always @(negedge clk) begin
      if (rst_n && done) begin
         if (sb.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL unexpected_done: got done=1 expected 0 (cycle %0d)",
                     cyc);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk("product", product, e.prod);
            chk("done_cycle", 64'(cyc), 64'(e.cyc));
         end
      end
   end

   // Presents operands for one cycle, then scrambles them so late changes
   // would be visible. Ends in the cycle after acceptance.
   task automatic issue(input logic [W-1:0] m, input logic [W-1:0] q,
                        input logic [2*W-1:0] exp, input int lat,
                        input bit push);
      exp_t e;
      @(posedge clk);
      #1;
      start  = 1'b1;
      mcand  = m;
      mplier = q;
      if (push) begin
         e.prod = exp;
         e.cyc  = cyc + lat;
         sb.push_back(e);
      end
      @(negedge clk);
      chk("stall_accept", 64'(stall), 64'd1);
      @(posedge clk);
      #1;
      start  = 1'b0;
      mcand  = ~m;
      mplier = ~q;
   endtask

   task automatic drain();
      int n = 0;
      while (sb.size() != 0 && n < 200) begin
         @(posedge clk);
         n++;
      end
      n_chk++;
      if (sb.size() != 0) begin
         n_fail++;
         $display("FAIL drain_timeout: got %0d pending expected 0",
                  sb.size());
         sb.delete();
      end
      repeat (2) @(posedge clk);
      #1;
   endtask

   initial begin
      int k;
      rst_n  = 1'b0;
      start  = 1'b0;
      flush  = 1'b0;
      mcand  = '0;
      mplier = '0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(negedge clk);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_done", 64'(done), 64'd0);
      chk("rst_stall", 64'(stall), 64'd0);
      chk("rst_product", product, 64'd0);

      // 3 * -2 with stall/busy tracked every cycle
      issue(32'd3, 32'hFFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFA, 33, 1'b1);
      for (int i = 1; i <= 32; i++) begin
         @(negedge clk);
         chk("stall_run", 64'(stall), 64'd1);
         chk("busy_run", 64'(busy), 64'd1);
      end
      @(negedge clk);
      chk("stall_done", 64'(stall), 64'd0);
      chk("done_pulse", 64'(done), 64'd1);
      drain();

      issue(32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, 33, 1'b1);
      drain();
      issue(32'h7FFF_FFFF, 32'h8000_0000, 64'hC000_0000_8000_0000, 33, 1'b1);
      drain();
      issue(32'h0000_1234, 32'hFFFF_FFFF, 64'hFFFF_FFFF_FFFF_EDCC, 33, 1'b1);
      drain();

      // back-to-back: start held across the DONE cycle
      @(posedge clk);
      #1;
      start  = 1'b1;
      mcand  = 32'd5;
      mplier = 32'd7;
      k = cyc;
      sb.push_back('{prod: 64'd35, cyc: k + 33});
      sb.push_back('{prod: 64'd1, cyc: k + 66});
      @(posedge clk);
      #1;
      mcand  = 32'hFFFF_FFFF;
      mplier = 32'hFFFF_FFFF;
      repeat (32) @(posedge clk);
      @(negedge clk);
      chk("b2b_stall_done", 64'(stall), 64'd1);
      @(posedge clk);
      #1;
      start = 1'b0;
      @(negedge clk);
      chk("b2b_busy", 64'(busy), 64'd1);
      drain();

      // flush mid-run: no done, product keeps 35
      issue(32'd5, 32'd7, 64'd35, 33, 1'b1);
      drain();
      issue(32'd9, 32'd9, 64'd0, 0, 1'b0);
      repeat (9) @(posedge clk);
      #1;
      flush = 1'b1;
      @(posedge clk);
      #1;
      flush = 1'b0;
      @(negedge clk);
      chk("flush_busy", 64'(busy), 64'd0);
      chk("flush_product", product, 64'd35);
      repeat (40) @(posedge clk);
      @(negedge clk);
      chk("flush_product_late", product, 64'd35);

      // flush with start in DONE: done still pulses, start dropped
      issue(32'hFFFF_FFF9, 32'd6, 64'hFFFF_FFFF_FFFF_FFD6, 33, 1'b1);
      repeat (32) @(posedge clk);
      #1;
      start  = 1'b1;
      flush  = 1'b1;
      mcand  = 32'd2;
      mplier = 32'd2;
      @(negedge clk);
      chk("flushdone_stall", 64'(stall), 64'd0);
      @(posedge clk);
      #1;
      start = 1'b0;
      flush = 1'b0;
      @(negedge clk);
      chk("flushdone_busy", 64'(busy), 64'd0);
      drain();

      // zero operand
      issue(32'd0, 32'h0000_1234, 64'd0, LAT_ZERO, 1'b1);
      @(negedge clk);
      chk("zero_stall_c1", 64'(stall), (LAT_ZERO == 1) ? 64'd0 : 64'd1);
      drain();

      // reset in the middle of a run
      issue(32'd11, 32'd13, 64'd0, 0, 1'b0);
      repeat (5) @(posedge clk);
      #1;
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(negedge clk);
      chk("midrst_busy", 64'(busy), 64'd0);
      chk("midrst_done", 64'(done), 64'd0);
      chk("midrst_product", product, 64'd0);
      repeat (40) @(posedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish expected finish by 200000");
      $fatal(1);
   end

endmodule
